adder_digit_serial: RTL and testbench
=====================================

Name: adder_digit_serial

Overview:
- Parametrised, multi-cycle add/subtract unit: the sequential successor to the combinational ripple-carry adder.
- Processes operands D bits per clock, LSB digit first, through one D-bit ripple slice, trading latency for area.
- Start/busy/done handshake toward the ALU control FSM; registered sum, carry-out and signed-overflow outputs.

Parameters:
- W, 9, operand/result width in bits.
- D, 3, digit width processed per cycle. W must be a multiple of D and D <= W; any other combination is an elaboration error. N = W/D digit cycles.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_b  input  1  synchronous active-low reset.
- start  input  1  request; accepted only on an edge where busy=0.
- x  input  W  operand A, sampled on the accepting edge only.
- y  input  W  operand B, sampled on the accepting edge only.
- op_sub  input  1  0: x+y+carry_in; 1: x-y (x + ~y + 1), carry_in ignored. Sampled on the accepting edge.
- carry_in  input  1  initial carry in add mode. Sampled on the accepting edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse, result valid.
- sum  output  W  registered result.
- carry_out  output  1  carry out of bit W-1. In subtract mode, 1 means no borrow.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_b=0 at edge): state=IDLE. busy=0, done=0, sum=0, carry_out=0, overflow=0, digit counter=0. Reset overrides everything, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE, or DONE with start=1:
  - Latch x, the effective y (~y if op_sub), and the initial carry (1 if op_sub, else carry_in).
  - Clear the counter, go to RUN.
- RUN (busy=1):
  - Each edge adds the low D bits of the A/B shift registers plus the carry register.
  - Shift the D-bit slice result into the result register from the MSB end; shift the operands right by D.
  - Update the carry register; counter++.
  - The edge processing digit N-1 also records the carry into the MSB, loads sum/carry_out/overflow, and moves to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - start=1 is accepted here for back-to-back operation: next state RUN.
  - Otherwise next state IDLE.
- start while busy=1 is ignored (not queued).
- Latency: done is high in the cycle following the N-th edge after the accepting edge. Throughput is one result per N+1 cycles.
- sum/carry_out/overflow change only on the edge entering DONE and hold until the next completion or reset. The x/y inputs are don't-care after acceptance.
- Arithmetic is modulo 2^W; bit-exact to a W-bit ripple-carry adder with the same effective inputs.
- D=W degenerates to a single RUN cycle (N=1), which is legal.

Optional Feature:
- Macro ADDER_SAT_EN.
- Defined: when overflow=1, sum is clamped to the signed limit instead of wrapping:
  - Positive overflow (sign of the raw result is 1) gives 0 followed by W-1 ones.
  - Negative overflow gives 1 followed by W-1 zeros.
  - carry_out and the overflow flag are reported unchanged.
- Not defined: sum wraps modulo 2^W; no clamp logic is present.

Test Plan (W=9, D=3, N=3):
- Reset: rst_b=0 for 2 cycles with start=1 -> busy=0, done=0, sum=0, carry_out=0, overflow=0.
- Add 5+3, carry_in=0 -> done on the 4th cycle after acceptance, sum=8, carry_out=0, overflow=0. Add 1+1 with carry_in=1 -> sum=3.
- Subtract, op_sub=1:
  - 5-3 -> sum=2, carry_out=1, overflow=0.
  - 0-1 -> sum=0x1FF, carry_out=0, overflow=0.
- Overflow:
  - 0x0FF+0x001 -> overflow=1, carry_out=0. Sum=0x100 without ADDER_SAT_EN; sum=0x0FF with it.
  - 0x1FF+0x001 -> sum=0, carry_out=1, overflow=0.
- Handshake:
  - start pulsed during RUN is ignored; the result matches the first operands.
  - start held high in the DONE cycle launches the next operation with no IDLE gap.
  - x/y changed after acceptance has no effect on the result.
- Reset mid-RUN: rst_b=0 after digit 1 -> next cycle IDLE, busy=0, outputs 0, no done pulse. A new start then completes correctly.

Source files
------------

// File: rtl/adder_digit_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder.
// The master drives start and operands; the slave returns status and result.
interface adder_digit_serial_if #(
    parameter int W = 9
);
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         op_sub;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output start, x, y, op_sub, carry_in,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, x, y, op_sub, carry_in,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_digit_serial.sv
// Digit-serial add/subtract: one D-bit ripple slice per clock, LSB digit first.
// Define ADDER_SAT_EN to clamp sum to the signed limit on overflow.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit per edge, busy=1
// DONE  | result valid, done=1 for one cycle; start here chains the next op
module adder_digit_serial #(
    parameter int W = 9,
    parameter int D = 3
) (
    input logic                 clk,
    input logic                 rst_b,
    adder_digit_serial_if.slave bus
);
    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((D < 1) || (D > W) || ((W % D) != 0)) begin : g_bad_cfg
            $error("adder_digit_serial: W must be a positive multiple of D with D <= W");
        end
    endgenerate

`ifdef ADDER_SAT_EN
    localparam logic [W-1:0] SAT_NEG = W'(1) << (W - 1);
    localparam logic [W-1:0] SAT_POS = ~SAT_NEG;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   res_q, res_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [D-1:0]   slice_sum;
    logic           slice_cout;
    logic           slice_cmsb;
    logic [W-1:0]   res_next;
    logic [W-1:0]   sum_fin;
    logic           ovf_fin;

    // slice_cmsb is the carry into the slice's top bit; on the last digit that is bit W-1
    always_comb begin : p_slice
        logic c;
        c          = carry_q;
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (i == D - 1) slice_cmsb = c;
            slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_cout = c;
    end

    always_comb begin
        res_next = W'({slice_sum, res_q} >> D);
        ovf_fin  = slice_cmsb ^ slice_cout;
`ifdef ADDER_SAT_EN
        if (ovf_fin) sum_fin = res_next[W-1] ? SAT_POS : SAT_NEG;
        else         sum_fin = res_next;
`else
        sum_fin = res_next;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.x;
                    b_d     = bus.op_sub ? ~bus.y : bus.y;
                    carry_d = bus.op_sub ? 1'b1 : bus.carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> D;
                b_d     = b_q >> D;
                res_d   = res_next;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = sum_fin;
                    cout_d  = slice_cout;
                    ovf_d   = ovf_fin;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_adder_digit_serial.sv
// Directed bench for adder_digit_serial with W=9, D=3 (three digit cycles).
// Expected sums follow ADDER_SAT_EN when it is defined for the build.
module tb_adder_digit_serial;
    localparam int W = 9;
    localparam int D = 3;

    logic clk;
    logic rst_b;
    int   checks;
    int   failures;

    adder_digit_serial_if #(.W(W)) bus ();

    adder_digit_serial #(.W(W), .D(D)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive operands with start at a negedge; returns one negedge after acceptance.
    task automatic issue(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic sub, input logic cin, input string tag);
        bus.start    = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        bus.op_sub   = sub;
        bus.carry_in = cin;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.x        = W'($urandom);
        bus.y        = W'($urandom);
        bus.op_sub   = 1'($urandom);
        bus.carry_in = 1'($urandom);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_nodone"}, 32'(bus.done), 32'd0);
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] esum,
                             input logic ecout, input logic eovf);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end while (!bus.done && cyc < 12);
        check({tag, "_latency"}, 32'(cyc), 32'd3);
        check({tag, "_sum"}, 32'(bus.sum), 32'(esum));
        check({tag, "_cout"}, 32'(bus.carry_out), 32'(ecout));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eovf));
    endtask

    task automatic check_idle(input string tag, input logic [W-1:0] esum);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_hold_sum"}, 32'(bus.sum), 32'(esum));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_b        = 1'b0;
        bus.start    = 1'b1;
        bus.x        = 9'h0AA;
        bus.y        = 9'h055;
        bus.op_sub   = 1'b0;
        bus.carry_in = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.carry_out), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        bus.start = 1'b0;
        rst_b     = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        issue(9'd5, 9'd3, 1'b0, 1'b0, "add5_3");
        wait_done("add5_3", 9'd8, 1'b0, 1'b0);
        check_idle("add5_3", 9'd8);

        issue(9'd1, 9'd1, 1'b0, 1'b1, "add1_1_c");
        wait_done("add1_1_c", 9'd3, 1'b0, 1'b0);
        check_idle("add1_1_c", 9'd3);

        issue(9'd5, 9'd3, 1'b1, 1'b0, "sub5_3");
        wait_done("sub5_3", 9'd2, 1'b1, 1'b0);
        check_idle("sub5_3", 9'd2);

        issue(9'd0, 9'd1, 1'b1, 1'b1, "sub0_1");
        wait_done("sub0_1", 9'h1FF, 1'b0, 1'b0);
        check_idle("sub0_1", 9'h1FF);

`ifdef ADDER_SAT_EN
        issue(9'h0FF, 9'h001, 1'b0, 1'b0, "posovf");
        wait_done("posovf", 9'h0FF, 1'b0, 1'b1);
        check_idle("posovf", 9'h0FF);
        issue(9'h100, 9'h001, 1'b1, 1'b0, "negovf");
        wait_done("negovf", 9'h100, 1'b1, 1'b1);
        check_idle("negovf", 9'h100);
`else
        issue(9'h0FF, 9'h001, 1'b0, 1'b0, "posovf");
        wait_done("posovf", 9'h100, 1'b0, 1'b1);
        check_idle("posovf", 9'h100);
        issue(9'h100, 9'h001, 1'b1, 1'b0, "negovf");
        wait_done("negovf", 9'h0FF, 1'b1, 1'b1);
        check_idle("negovf", 9'h0FF);
`endif

        issue(9'h1FF, 9'h001, 1'b0, 1'b0, "wrap");
        wait_done("wrap", 9'h000, 1'b1, 1'b0);
        check_idle("wrap", 9'h000);

        // start pulsed while busy must be dropped, not queued
        issue(9'd2, 9'd2, 1'b0, 1'b0, "ignore");
        bus.start = 1'b1;
        bus.x     = 9'h0AA;
        bus.y     = 9'h055;
        wait_done("ignore", 9'd4, 1'b0, 1'b0);
        check_idle("ignore", 9'd4);

        // back-to-back: start presented during the DONE cycle
        issue(9'd100, 9'd50, 1'b0, 1'b0, "b2b_a");
        wait_done("b2b_a", 9'd150, 1'b0, 1'b0);
        issue(9'd20, 9'd30, 1'b1, 1'b0, "b2b_b");
        wait_done("b2b_b", 9'h1F6, 1'b0, 1'b0);
        check_idle("b2b_b", 9'h1F6);

        // reset after digit 1 discards the operation
        issue(9'd7, 9'd7, 1'b0, 1'b0, "midrst");
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.carry_out), 32'd0);
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        rst_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", 32'(bus.done), 32'd0);
        end

        issue(9'd6, 9'd7, 1'b0, 1'b0, "after_rst");
        wait_done("after_rst", 9'd13, 1'b0, 1'b0);
        check_idle("after_rst", 9'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
